uart_tx_arb: RTL
================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter N_REQ, default 4, number of byte-stream requesters sharing one UART transmitter (range 2..8).
REQ-002 Parameter HOLD_TIMEOUT, default 0, idle cycles in HOLD before a packet grant is forcibly released; 0 disables the timeout.
REQ-003 clk  input  1  clock.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_data  input  8*N_REQ  byte from requester i on bits [8i+7:8i].
REQ-006 req_last  input  N_REQ  requester i's byte is the last of its packet.
REQ-007 req_valid  input  N_REQ  requester i presents a byte; held stable with data/last until req_ack[i].
REQ-008 req_ack  output  N_REQ  one-cycle pulse: requester i's byte was accepted by the transmitter.
REQ-009 tx_data  output  8  byte to the transmitter.
REQ-010 tx_valid  output  1  byte available; held with stable tx_data until tx_ack.
REQ-011 tx_ack  input  1  transmitter accepted tx_data (one-cycle pulse).
REQ-012 grant  output  N_REQ  one-hot owner of the transmitter; all-zero when idle.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, ACK and HOLD.
REQ-015 All outputs SHALL be registered.
REQ-016 IDLE: if any req_valid is high, the block SHALL select a winner round-robin, starting at the index after the last granted requester (wrapping N_REQ-1 -> 0).
REQ-017 On that selection, the next cycle SHALL show grant[i]=1, tx_data=req_data[i], tx_valid=1, state WAIT, and the captured req_last[i] stored internally.
REQ-018 Grant latency SHALL be exactly 1 cycle from req_valid high in IDLE to tx_valid high.
REQ-019 WAIT: tx_valid and tx_data SHALL stay constant until tx_ack=1.
REQ-020 On the cycle after tx_ack, the block SHALL drive tx_valid=0 and req_ack[i]=1 for exactly one cycle, and enter state ACK.
REQ-021 ACK: req_valid SHALL be ignored.
REQ-022 ACK then goes to IDLE if the stored last flag is 1, clearing grant and recording i as last granted.
REQ-023 ACK otherwise goes to HOLD with grant kept.
REQ-024 HOLD: the first cycle with req_valid[i]=1 SHALL produce, on the next cycle, tx_valid=1 with the new req_data[i]/req_last[i] captured, and state WAIT.
REQ-025 HOLD: other requesters SHALL NOT be granted while requester i holds the packet.
REQ-026 HOLD with HOLD_TIMEOUT>0: after HOLD_TIMEOUT consecutive HOLD cycles with req_valid[i]=0, the block SHALL return to IDLE, clear grant and record i as last granted.
REQ-027 The HOLD timeout counter SHALL reset on entry to HOLD and saturate; its width SHALL be clog2(HOLD_TIMEOUT+1).
REQ-028 tx_ack while not in WAIT SHALL be ignored.
REQ-029 req_valid[i] deasserting during WAIT SHALL NOT cancel the byte; req_ack[i] is still issued.
REQ-030 req_valid from non-granted requesters SHALL never produce req_ack.
REQ-031 At most one bit of grant and one bit of req_ack SHALL be high in any cycle.
REQ-032 req_ack SHALL only pulse on the granted index.

Reset
REQ-033 While rst is high, the block SHALL drive state=IDLE, grant=0, req_ack=0, tx_valid=0, tx_data=0, busy=0, last-granted pointer=N_REQ-1 (requester 0 highest priority first), and timeout counter=0.
REQ-034 Reset asserted mid-packet SHALL abandon the packet without issuing req_ack.

Verification
REQ-035 Single byte: req_valid[2]=1, data 0x55, last=1 at cycle 0 -> cycle 1 grant=0100, tx_valid=1, tx_data=0x55; tx_ack at cycle 5 -> cycle 6 req_ack=0100, tx_valid=0; cycle 7 grant=0, busy=0.
REQ-036 Round-robin: all four requesters valid with single-byte packets after reset -> grant order 0,1,2,3,0, each with exactly one req_ack.
REQ-037 Packet lock: requester 1 sends 3 bytes (last on the third) while requester 0 stays valid -> bytes 1a,1b,1c transmitted back-to-back, then requester 2's turn (if valid) else 0; requester 0 is never granted mid-packet.
REQ-038 Timeout: HOLD_TIMEOUT=4, requester 3 sends a non-last byte then drops req_valid -> grant released exactly 4 cycles after HOLD entry; requester 0 is granted next.
REQ-039 Spurious/abort: tx_ack pulse in IDLE -> no output change; rst pulse in WAIT -> tx_valid=0, grant=0 next edge, no req_ack, and next arbitration starts at requester 0.

Source files
------------

// File: rtl/uart_tx_arb_if.sv
// Requester/transmitter bundle for the shared UART transmit arbiter.
// The master side is the arbiter; the slave side is the requesters plus the transmitter.
interface uart_tx_arb_if #(
  parameter int N_REQ = 4
);
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ack;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ack;
  logic [N_REQ-1:0]   grant;
  logic               busy;

  modport master (
    input  req_data, req_last, req_valid, tx_ack,
    output req_ack, tx_data, tx_valid, grant, busy
  );

  modport slave (
    output req_data, req_last, req_valid, tx_ack,
    input  req_ack, tx_data, tx_valid, grant, busy
  );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte-stream requesters.
// A grant is held for a whole packet (until a byte flagged last), with an optional idle timeout.
module uart_tx_arb #(
  parameter int N_REQ        = 4,
  parameter int HOLD_TIMEOUT = 0
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_arb_if.master bus
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

  state_t           state_reg, state_next;
  logic [N_REQ-1:0] grant_reg, grant_next;
  logic [N_REQ-1:0] req_ack_reg, req_ack_next;
  logic [7:0]       tx_data_reg, tx_data_next;
  logic             tx_valid_reg, tx_valid_next;
  logic             busy_reg, busy_next;
  logic             last_flag_reg, last_flag_next;
  logic [IW-1:0]    gidx_reg, gidx_next;
  logic [IW-1:0]    last_grant_reg, last_grant_next;
  logic [CW-1:0]    tmo_cnt_reg, tmo_cnt_next;

  logic [7:0]       lane_data [N_REQ];
  logic [IW-1:0]    win_idx;
  logic             win_found;
  int               cand;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
      assign lane_data[gi] = bus.req_data[8*gi +: 8];
    end
  endgenerate

  // Search starts one past the last granted requester so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(last_grant_reg) + k) % N_REQ;
      if (!win_found && bus.req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = IW'(cand);
      end
    end
  end

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    req_ack_next    = '0;
    tx_data_next    = tx_data_reg;
    tx_valid_next   = tx_valid_reg;
    last_flag_next  = last_flag_reg;
    gidx_next       = gidx_reg;
    last_grant_next = last_grant_reg;
    tmo_cnt_next    = tmo_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (win_found) begin
          state_next     = WAIT;
          gidx_next      = win_idx;
          grant_next     = N_REQ'(1) << win_idx;
          tx_data_next   = lane_data[win_idx];
          tx_valid_next  = 1'b1;
          last_flag_next = bus.req_last[win_idx];
        end
      end
      WAIT: begin
        if (bus.tx_ack) begin
          state_next    = ACK;
          tx_valid_next = 1'b0;
          req_ack_next  = grant_reg;
        end
      end
      ACK: begin
        if (last_flag_reg) begin
          state_next      = IDLE;
          grant_next      = '0;
          last_grant_next = gidx_reg;
        end else begin
          state_next   = HOLD;
          tmo_cnt_next = '0;
        end
      end
      HOLD: begin
        if (bus.req_valid[gidx_reg]) begin
          state_next     = WAIT;
          tx_data_next   = lane_data[gidx_reg];
          tx_valid_next  = 1'b1;
          last_flag_next = bus.req_last[gidx_reg];
        end else if (HOLD_TIMEOUT > 0 && int'(tmo_cnt_reg) == HOLD_TIMEOUT - 1) begin
          state_next      = IDLE;
          grant_next      = '0;
          last_grant_next = gidx_reg;
        end else if (int'(tmo_cnt_reg) < HOLD_TIMEOUT) begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      req_ack_reg    <= '0;
      tx_data_reg    <= '0;
      tx_valid_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      last_flag_reg  <= 1'b0;
      gidx_reg       <= '0;
      last_grant_reg <= IW'(N_REQ - 1);
      tmo_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      req_ack_reg    <= req_ack_next;
      tx_data_reg    <= tx_data_next;
      tx_valid_reg   <= tx_valid_next;
      busy_reg       <= busy_next;
      last_flag_reg  <= last_flag_next;
      gidx_reg       <= gidx_next;
      last_grant_reg <= last_grant_next;
      tmo_cnt_reg    <= tmo_cnt_next;
    end
  end

  assign bus.grant    = grant_reg;
  assign bus.req_ack  = req_ack_reg;
  assign bus.tx_data  = tx_data_reg;
  assign bus.tx_valid = tx_valid_reg;
  assign bus.busy     = busy_reg;
endmodule
